sbox_multi_eval_ctrl: RTL

- Controller for evaluating masked S-boxes with NCH parallel lanes. Replaces the single-lane, fixed-latency, fixed-mask-width evaluation wrapper.
- Loads a key, a multi-beat random-mask stream and a 128-bit data block, then drives the external S-box array with (data ^ key) lanes plus mask words.
- Waits a parametrised latency, captures the S-box outputs into Dout and pulses Dvld.
- Sits between the host I/O framework and the external S-box instances.

---
 rtl/sbox_multi_eval_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sbox_multi_eval_ctrl.sv
// Masked S-box evaluation controller with NCH parallel lanes.
//
// Loads a 128-bit key, a multi-beat mask stream and a 128-bit data block, then presents
// (data ^ key) lanes plus mask words to an external S-box array. After LAT cycles the
// array outputs are captured into Dout and Dvld pulses for one cycle.
//
// Ports:
//   CLK, RSTn      clock, asynchronous active-low reset
//   EN             global enable; when low, state holds and strobes are ignored
//   Kin/Krdy/Kvld  key load and one-cycle accept pulse
//   Rin/Rrdy       mask beats; the first beat lands in the MSBs of the buffer
//   Din/Drdy       data block and start strobe
//   Dout/Dvld      captured result and one-cycle valid pulse
//   BSY            operation in progress
//   Err            one-cycle pulse when Drdy arrives before the mask buffer is full
//   sbox_x/r/y     external S-box array interface, lane 0 in the MSBs
//
// Optional feature macro MASK_REUSE_EN: when defined, the beat count is not cleared at
// operation start, so one mask load serves every later operation until reset.
module sbox_multi_eval_ctrl #(
  parameter int unsigned D   = 8,
  parameter int unsigned NR  = 7,
  parameter int unsigned NCH = 1,
  parameter int unsigned LAT = 10
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  EN,
  input  logic [127:0]          Kin,
  input  logic                  Krdy,
  output logic                  Kvld,
  input  logic [127:0]          Rin,
  input  logic                  Rrdy,
  input  logic [127:0]          Din,
  input  logic                  Drdy,
  output logic [127:0]          Dout,
  output logic                  Dvld,
  output logic                  BSY,
  output logic                  Err,
  output logic [NCH*D-1:0]      sbox_x,
  output logic [NCH*NR*D-1:0]   sbox_r,
  input  logic [NCH*D-1:0]      sbox_y
);

  localparam int unsigned MaskBits = NCH * NR * D;
  localparam int unsigned NBeats   = (MaskBits + 127) / 128;
  localparam int unsigned MaskW    = NBeats * 128;
  localparam int unsigned CntW     = $clog2(NBeats + 1);
  localparam int unsigned LatW     = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [127:0]      key_q, key_d;
  logic [127:0]      dat_q, dat_d;
  logic [MaskW-1:0]  mask_q, mask_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [127:0]      dout_q, dout_d;
  logic              dvld_q, dvld_d;
  logic              kvld_q, kvld_d;
  logic              err_q, err_d;

  logic [MaskW-1:0]  mask_shift;
  logic [127:0]      dout_cap;
  logic [127:0]      xor_w;
  logic              mask_full;

  assign mask_full = (cnt_q == CntW'(NBeats));
  assign xor_w     = dat_q ^ key_q;

  // Shift the new beat in at the bottom; a single-beat buffer is simply replaced.
  if (NBeats == 1) begin : g_shift_one
    assign mask_shift = Rin;
  end else begin : g_shift_multi
    assign mask_shift = {mask_q[MaskW-129:0], Rin};
  end

  // Lane i occupies the top D bits of byte i of the 128-bit block.
  always_comb begin
    sbox_x   = '0;
    dout_cap = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      sbox_x[NCH*D-1-i*D -: D] = xor_w[127-8*i -: D];
      dout_cap[127-8*i -: D]   = sbox_y[NCH*D-1-i*D -: D];
    end
  end

  assign sbox_r = mask_q[MaskW-1 -: MaskBits];

  // Bits of the key/data block outside the lanes and unused low mask bits are intentionally
  // not observed.
  logic unused_bits;
  assign unused_bits = ^{xor_w, mask_q};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    kvld_d  = 1'b0;
    err_d   = 1'b0;
    if (EN) begin
      unique case (state_q)
        StIdle: begin
          if (Krdy) begin
            key_d  = Kin;
            kvld_d = 1'b1;
          end
          if (Drdy && mask_full) begin
            // A concurrent Rrdy is dropped here: the buffer is already full.
            dat_d   = Din;
            state_d = StRun;
            lat_d   = '0;
`ifndef MASK_REUSE_EN
            cnt_d   = '0;
`endif
          end else begin
            if (Rrdy && !mask_full) begin
              mask_d = mask_shift;
              cnt_d  = cnt_q + CntW'(1);
            end
            if (Drdy) begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (lat_q == LatW'(LAT - 1)) begin
            dout_d  = dout_cap;
            dvld_d  = 1'b1;
            state_d = StIdle;
          end else begin
            lat_d = lat_q + LatW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      key_q   <= '0;
      dat_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      kvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      dout_q  <= dout_d;
      // Pulses are never stretched, including while EN is low.
      dvld_q  <= dvld_d;
      kvld_q  <= kvld_d;
      err_q   <= err_d;
    end
  end

  assign Dout = dout_q;
  assign Dvld = dvld_q;
  assign Kvld = kvld_q;
  assign Err  = err_q;
  assign BSY  = (state_q == StRun);

endmodule
